// File: rtl/sprite_pos_updater_pkg.sv
// Shared encodings for sprite movement: direction codes from the movement FSM
// and the position updater's state encoding.
package sprite_pos_updater_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'b000,
        DIR_LEFT  = 3'b001,
        DIR_RIGHT = 3'b010,
        DIR_UP    = 3'b011,
        DIR_DOWN  = 3'b100
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/sprite_pos_updater_coord_step_clamp.sv
// One saturating coordinate step: moves by STEP toward MIN or MAX and stops at the bound.
// 11-bit intermediates keep the comparison free of wrap-around.
module coord_step_clamp #(
    parameter int STEP = 4,
    parameter int MIN  = 0,
    parameter int MAX  = 620
) (
    input  logic [9:0] coord,
    input  logic       dec,
    input  logic       inc,
    output logic [9:0] result
);

    localparam logic [10:0] LO_LIMIT = 11'(MIN + STEP);
    localparam logic [10:0] HI_LIMIT = 11'(MAX - STEP);
    localparam logic [10:0] STEP_W   = 11'(STEP);

    logic [10:0] wide;

    always_comb begin
        wide   = {1'b0, coord};
        result = coord;
        if (dec) begin
            result = (wide < LO_LIMIT) ? 10'(MIN) : 10'(wide - STEP_W);
        end else if (inc) begin
            result = (wide > HI_LIMIT) ? 10'(MAX) : 10'(wide + STEP_W);
        end
    end

endmodule

// File: rtl/sprite_pos_updater.sv
// Sprite position updater: steps the position on move pulses, saturating at the
// screen bounds, and writes each new position to the sprite register bank.
module sprite_pos_updater
    import sprite_pos_updater_pkg::*;
#(
    parameter int STEP   = 4,
    parameter int X_MIN  = 0,
    parameter int X_MAX  = 620,
    parameter int Y_MIN  = 0,
    parameter int Y_MAX  = 460,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  direction,
    input  logic        move_pulse,
    input  logic        wr_ack,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        wr_req,
    output logic [19:0] wr_data,
    output logic        blocked,
    output logic        overrun
);

    state_e     state, state_next;
    logic [2:0] cur_dir;
    logic [2:0] pend_dir;
    logic       pend_valid;
    logic [9:0] x_next, y_next;
    logic       valid_dir, moved, leave;

    coord_step_clamp #(.STEP(STEP), .MIN(X_MIN), .MAX(X_MAX)) u_step_x (
        .coord  (pos_x),
        .dec    (cur_dir == DIR_LEFT),
        .inc    (cur_dir == DIR_RIGHT),
        .result (x_next)
    );

    coord_step_clamp #(.STEP(STEP), .MIN(Y_MIN), .MAX(Y_MAX)) u_step_y (
        .coord  (pos_y),
        .dec    (cur_dir == DIR_UP),
        .inc    (cur_dir == DIR_DOWN),
        .result (y_next)
    );

    // STEP ends either in WRITE (position changed) or by leaving; leaving with a
    // queued or simultaneous request re-enters STEP immediately.
    always_comb begin
        valid_dir  = cur_dir inside {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN};
        moved      = valid_dir && ((x_next != pos_x) || (y_next != pos_y));
        leave      = ((state == ST_STEP) && !moved) || ((state == ST_WRITE) && wr_ack);
        state_next = state;
        case (state)
            ST_IDLE:  if (move_pulse) state_next = ST_STEP;
            ST_STEP:  if (moved) state_next = ST_WRITE;
            ST_WRITE: ;
            default:  state_next = ST_IDLE;
        endcase
        if (leave) begin
            state_next = (pend_valid || move_pulse) ? ST_STEP : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pos_x      <= 10'(X_INIT);
            pos_y      <= 10'(Y_INIT);
            cur_dir    <= DIR_NONE;
            pend_dir   <= DIR_NONE;
            pend_valid <= 1'b0;
            blocked    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_next;
            blocked <= (state == ST_STEP) && valid_dir && !moved;
            if ((state == ST_STEP) && moved) begin
                pos_x <= x_next;
                pos_y <= y_next;
            end
            if ((state == ST_IDLE) && move_pulse) begin
                cur_dir <= direction;
            end else if (leave) begin
                if (pend_valid) begin
                    cur_dir    <= pend_dir;
                    pend_valid <= move_pulse;
                    if (move_pulse) pend_dir <= direction;
                end else if (move_pulse) begin
                    cur_dir <= direction;
                end
            end else if ((state != ST_IDLE) && move_pulse) begin
                if (pend_valid) overrun <= 1'b1;
                pend_valid <= 1'b1;
                pend_dir   <= direction;
            end
        end
    end

    // Handshake: wr_req holds with wr_data stable until a cycle with wr_ack=1;
    // that cycle completes the transfer and wr_req drops on the next one.
    assign wr_req  = (state == ST_WRITE);
    assign wr_data = {pos_y, pos_x};

endmodule

// File: tb/tb_sprite_pos_updater.sv
// Bench for sprite_pos_updater: directed corner cases plus random pulses/acks,
// checked every cycle against a request-level model and a write scoreboard.
module tb_sprite_pos_updater;

    localparam int STEP = 4, X_MIN = 0, X_MAX = 620, Y_MIN = 0, Y_MAX = 460;
    localparam int X_INIT = 320, Y_INIT = 240;
    localparam int PH_IDLE = 0, PH_STEP = 1, PH_WRITE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  direction = 3'd0;
    logic        move_pulse = 1'b0;
    logic        wr_ack = 1'b0;
    logic [9:0]  pos_x, pos_y, e_pos_x, e_pos_y;
    logic        wr_req, blocked, overrun, e_wr_req, e_blocked, e_overrun;
    logic [19:0] wr_data, e_wr_data;

    int n_checks = 0;
    int n_pass = 0;

    int          m_phase, m_x, m_y;
    logic [2:0]  m_dir;
    logic        m_blocked, m_overrun;
    logic [2:0]  pend_q[$];
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    sprite_pos_updater dut (
        .clk(clk), .reset(reset), .direction(direction), .move_pulse(move_pulse),
        .wr_ack(wr_ack), .pos_x(pos_x), .pos_y(pos_y), .wr_req(wr_req),
        .wr_data(wr_data), .blocked(blocked), .overrun(overrun)
    );

    sprite_pos_updater #(.X_INIT(2), .Y_INIT(458)) dut_edge (
        .clk(clk), .reset(reset), .direction(direction), .move_pulse(move_pulse),
        .wr_ack(wr_ack), .pos_x(e_pos_x), .pos_y(e_pos_y), .wr_req(e_wr_req),
        .wr_data(e_wr_data), .blocked(e_blocked), .overrun(e_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_x = X_INIT; m_y = Y_INIT; m_dir = 3'd0;
        m_blocked = 1'b0; m_overrun = 1'b0;
        pend_q.delete(); exp_q.delete();
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_advance(input logic mp, input logic [2:0] d, input logic ack);
        int  old_phase = m_phase;
        int  nx = m_x;
        int  ny = m_y;
        bit  legal = (m_dir >= 3'd1) && (m_dir <= 3'd4);
        bit  leave = 1'b0;
        m_blocked = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (mp) begin m_dir = d; m_phase = PH_STEP; end
        end else if (m_phase == PH_STEP) begin
            if (m_dir == 3'd1) nx = clamp(m_x - STEP, X_MIN, X_MAX);
            if (m_dir == 3'd2) nx = clamp(m_x + STEP, X_MIN, X_MAX);
            if (m_dir == 3'd3) ny = clamp(m_y - STEP, Y_MIN, Y_MAX);
            if (m_dir == 3'd4) ny = clamp(m_y + STEP, Y_MIN, Y_MAX);
            if (legal && (nx != m_x || ny != m_y)) begin
                m_x = nx; m_y = ny; m_phase = PH_WRITE;
                exp_q.push_back({10'(ny), 10'(nx)});
            end else begin
                m_blocked = legal;
                leave = 1'b1;
            end
        end else if (ack) begin
            leave = 1'b1;
        end
        if (old_phase != PH_IDLE) begin
            if (leave) begin
                if (pend_q.size() > 0) begin
                    m_dir = pend_q.pop_front(); m_phase = PH_STEP;
                    if (mp) pend_q.push_back(d);
                end else if (mp) begin
                    m_dir = d; m_phase = PH_STEP;
                end else begin
                    m_phase = PH_IDLE;
                end
            end else if (mp) begin
                if (pend_q.size() > 0) begin m_overrun = 1'b1; pend_q.delete(); end
                pend_q.push_back(d);
            end
        end
    endtask

    task automatic compare_all();
        check("pos_x", pos_x, m_x);
        check("pos_y", pos_y, m_y);
        check("wr_req", wr_req, m_phase == PH_WRITE);
        check("blocked", blocked, m_blocked);
        check("overrun", overrun, m_overrun);
        if (m_phase == PH_WRITE) check("wr_data", wr_data, {10'(m_y), 10'(m_x)});
    endtask

    // Called at a falling edge: drive one cycle of inputs, then compare at the next falling edge.
    task automatic drive_cycle(input logic mp, input logic [2:0] d, input logic ack);
        logic [19:0] exp_w;
        move_pulse = mp; direction = d; wr_ack = ack;
        if (m_phase == PH_WRITE && ack) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else begin exp_w = exp_q.pop_front(); check("sb_wr_data", wr_data, exp_w); end
        end
        model_advance(mp, d, ack);
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        move_pulse = 1'b0; wr_ack = 1'b0; direction = 3'd0;
        reset = 1'b0; #1; reset = 1'b1; #1;
        check("rst_pos_x", pos_x, X_INIT);
        check("rst_pos_y", pos_y, Y_INIT);
        check("rst_wr_req", wr_req, 0);
        check("rst_blocked", blocked, 0);
        check("rst_overrun", overrun, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int x0, y0;
        apply_reset();

        // Edge instance starts at (2,458): saturate, then get blocked.
        drive_cycle(1, 3'b001, 1);
        drive_cycle(0, 3'd0, 1);
        check("edge_left_x", e_pos_x, 0);
        check("edge_left_req", e_wr_req, 1);
        check("edge_left_data", e_wr_data, (458 << 10) | 0);
        drive_cycle(0, 3'd0, 1);
        drive_cycle(1, 3'b001, 1);
        check("edge_left2_req_c1", e_wr_req, 0);
        drive_cycle(0, 3'd0, 1);
        check("edge_left2_blocked", e_blocked, 1);
        check("edge_left2_req", e_wr_req, 0);
        check("edge_left2_x", e_pos_x, 0);
        drive_cycle(0, 3'd0, 1);
        check("edge_blocked_once", e_blocked, 0);
        drive_cycle(1, 3'b100, 1);
        drive_cycle(0, 3'd0, 1);
        check("edge_down_y", e_pos_y, 460);
        check("edge_down_req", e_wr_req, 1);
        drive_cycle(0, 3'd0, 1);
        drive_cycle(1, 3'b100, 1);
        drive_cycle(0, 3'd0, 1);
        check("edge_down2_blocked", e_blocked, 1);
        check("edge_down2_y", e_pos_y, 460);
        check("edge_down2_req", e_wr_req, 0);
        drive_cycle(0, 3'd0, 1);

        // Basic right step with a delayed ack.
        apply_reset();
        drive_cycle(1, 3'b010, 0);
        check("right_c1_x", pos_x, 320);
        check("right_c1_req", wr_req, 0);
        drive_cycle(0, 3'd0, 0);
        check("right_c2_x", pos_x, 324);
        check("right_c2_req", wr_req, 1);
        check("right_c2_data", wr_data, (240 << 10) | 324);
        drive_cycle(0, 3'd0, 0);
        drive_cycle(0, 3'd0, 0);
        check("right_hold_req", wr_req, 1);
        check("right_hold_data", wr_data, (240 << 10) | 324);
        drive_cycle(0, 3'd0, 1);
        check("right_after_ack_req", wr_req, 0);
        drive_cycle(0, 3'd0, 0);

        // Two requests during WRITE: the later one (left) replaces the earlier (up).
        x0 = m_x; y0 = m_y;
        drive_cycle(1, 3'b010, 0);
        drive_cycle(0, 3'd0, 0);
        drive_cycle(1, 3'b011, 0);
        drive_cycle(1, 3'b001, 0);
        check("ovr_set", overrun, 1);
        drive_cycle(0, 3'd0, 1);
        drive_cycle(0, 3'd0, 0);
        check("ovr_left_x", pos_x, x0);
        check("ovr_y_kept", pos_y, y0);
        check("ovr_left_req", wr_req, 1);
        drive_cycle(0, 3'd0, 1);
        drive_cycle(0, 3'd0, 0);
        check("ovr_sticky", overrun, 1);

        // Unused direction code, then reset in the middle of a write.
        x0 = m_x; y0 = m_y;
        drive_cycle(1, 3'b110, 1);
        drive_cycle(0, 3'd0, 1);
        check("bad_dir_req", wr_req, 0);
        check("bad_dir_blocked", blocked, 0);
        check("bad_dir_x", pos_x, x0);
        check("bad_dir_y", pos_y, y0);
        drive_cycle(1, 3'b010, 0);
        drive_cycle(0, 3'd0, 0);
        check("pre_rst_req", wr_req, 1);
        apply_reset();

        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)),
                        $urandom_range(0, 9) < 4);
        end
        for (int i = 0; i < 8; i++) drive_cycle(0, 3'd0, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_pos_updater.md
SPRITE_POS_UPDATER -- requirements
Module: sprite_pos_updater

Interface
REQ-001 Parameter STEP, 4, pixels moved per accepted move pulse (1..15).
REQ-002 Parameter X_MIN, 0, lowest legal sprite X.
REQ-003 Parameter X_MAX, 620, highest legal sprite X.
REQ-004 Parameter Y_MIN, 0, lowest legal sprite Y.
REQ-005 Parameter Y_MAX, 460, highest legal sprite Y.
REQ-006 Parameters X_INIT, 320 and Y_INIT, 240, position loaded at reset.
REQ-007 clk  in  1  system clock; all state changes on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 direction  in  3  movement code from the movement FSM: 000 none, 001 left, 010 right, 011 up, 100 down.
REQ-010 move_pulse  in  1  one-cycle request to step once in the current direction.
REQ-011 wr_ack  in  1  sprite register bank accepted wr_data.
REQ-012 pos_x  out  10  current X coordinate.
REQ-013 pos_y  out  10  current Y coordinate.
REQ-014 wr_req  out  1  write request to the sprite register bank.
REQ-015 wr_data  out  20  {pos_y, pos_x}, stable while wr_req is high.
REQ-016 blocked  out  1  one-cycle pulse: step rejected because the coordinate is already at its bound.
REQ-017 overrun  out  1  sticky: a move request was lost.

Function
REQ-018 The FSM SHALL have states IDLE, STEP and WRITE.
REQ-019 In IDLE, move_pulse=1 SHALL capture direction and go to STEP; move_pulse=0 SHALL stay in IDLE.
REQ-020 STEP SHALL last exactly one cycle and compute the new coordinate in that cycle.
REQ-021 Left: x<X_MIN+STEP -> X_MIN, else x-STEP. Right: x>X_MAX-STEP -> X_MAX, else x+STEP. Up/down: same rule on y with Y_MIN/Y_MAX. Arithmetic is 11-bit so no wrap-around.
REQ-022 Codes 000 and 101-111 SHALL leave the position unchanged, issue no write, and return to IDLE.
REQ-023 If the computed coordinate equals the old one, STEP SHALL pulse blocked for one cycle, issue no write, and return to IDLE.
REQ-024 Otherwise, STEP SHALL update pos_x/pos_y and go to WRITE; wr_req SHALL be high from the next cycle.
REQ-025 move_pulse high in cycle c (IDLE, pending empty) SHALL give the updated pos and wr_req=1 in cycle c+2.
REQ-026 In WRITE, wr_req SHALL stay high and wr_data constant until a cycle with wr_ack=1; wr_req SHALL be low in the following cycle.
REQ-027 wr_ack while not in WRITE SHALL be ignored.
REQ-028 move_pulse arriving in STEP or WRITE SHALL be stored, with its direction, in a one-deep pending slot.
REQ-029 If the slot is already full, the newer request SHALL replace it and overrun SHALL set.
REQ-030 Leaving WRITE (ack) or STEP (no write) with the slot full SHALL go directly to STEP using the pending direction and clear the slot.
REQ-031 A move_pulse in the same cycle the slot is consumed SHALL refill the slot without setting overrun.

Reset
REQ-032 Reset SHALL force IDLE, pos_x=X_INIT, pos_y=Y_INIT, wr_req=0, blocked=0, overrun=0, and an empty pending slot.
REQ-033 Reset during WRITE SHALL drop the request immediately, with no ack required.
REQ-034 Only reset SHALL clear overrun.

Structure
REQ-035 The direction codes (3'b000..3'b100) and FSM state encodings SHALL live in a shared package also used by the movement FSM.
REQ-036 The saturating step of REQ-021 SHALL be one sub-module, coord_step_clamp, instantiated once for X and once for Y.

Verification
REQ-037 After reset, pulse move with direction=010 and hold wr_ack=0 for 3 cycles -> pos_x=324 at c+2; wr_req high until the ack; wr_data=(240<<10)|324.
REQ-038 From x=2, pulse direction=001 -> pos_x=0 and a write occurs; pulse again -> blocked pulses, no wr_req.
REQ-039 From y=458, pulse direction=100 -> pos_y=460; pulse again -> blocked, pos_y stays 460.
REQ-040 During WRITE, pulse direction=011 then 001 with no ack, then ack -> overrun=1; next step is left only, and pos_y is unchanged.
REQ-041 Pulse with direction=110 -> no change, no write; assert reset mid-WRITE -> wr_req=0 and position=(320,240) at once.
